// File: rtl/freq_meter.sv
// freq_meter: measures an asynchronous input clock against CLK.
// Gate mode counts sig_in rising edges over a fixed window of GATE_CYCLES
// clocks (frequency). Period mode counts CLK cycles between two consecutive
// sig_in rising edges. Each result is registered and marked by a one-cycle
// valid strobe, with ovf flagging a saturated count.
`timescale 1ns/1ps

module freq_meter #(
    parameter int          CW          = 32,
    parameter logic [31:0] GATE_CYCLES = 32'd100000000
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          sig_in,
    input  logic          start,
    input  logic          mode,
    input  logic          cont,
    output logic [CW-1:0] result,
    output logic          valid,
    output logic          ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ACC_MAX  = '1;
    localparam logic [CW-1:0] ACC_ZERO = '0;
    localparam logic [CW-1:0] ACC_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   GT_LOAD  = GATE_CYCLES - 32'd1;

    // Synchronizer and edge-history flops
    logic r_s1, r_s2, r_s3;

    // Measurement state
    state_t        r_state;
    logic          r_m;
    logic [31:0]   r_gt;
    logic [CW-1:0] r_acc;
    logic          r_acc_sat;
    logic [CW-1:0] r_result;
    logic          r_valid;
    logic          r_ovf;

    // Next-state values
    state_t        w_state_nxt;
    logic          w_m_nxt;
    logic [31:0]   w_gt_nxt;
    logic [CW-1:0] w_acc_nxt;
    logic          w_acc_sat_nxt;
    logic [CW-1:0] w_result_nxt;
    logic          w_valid_nxt;
    logic          w_ovf_nxt;
    logic          w_finish;

    // Datapath helpers
    logic          w_edge;
    logic          w_acc_full;
    logic          w_gate_ovf;
    logic [CW-1:0] w_gate_sum;
    logic [CW-1:0] w_per_sum;

    // Bring sig_in into the CLK domain and keep one cycle of history for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source regardless of statement order.
        if (RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge     = r_s2 & ~r_s3;
    assign w_acc_full = (r_acc == ACC_MAX);

    // Gate mode: the sticky flag keeps ovf set once the count has passed all-ones,
    // even if no further edge arrives before the window closes.
    assign w_gate_ovf = r_acc_sat | (w_acc_full & w_edge);
    assign w_gate_sum = w_gate_ovf ? ACC_MAX : (w_edge ? r_acc + ACC_ONE : r_acc);

    // Period mode: cycles between strobes, capped at all-ones
    assign w_per_sum  = w_acc_full ? ACC_MAX : r_acc + ACC_ONE;

    // State and datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_m       <= 1'b0;
            r_gt      <= 32'd0;
            r_acc     <= ACC_ZERO;
            r_acc_sat <= 1'b0;
            r_result  <= ACC_ZERO;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_gt      <= w_gt_nxt;
            r_acc     <= w_acc_nxt;
            r_acc_sat <= w_acc_sat_nxt;
            r_result  <= w_result_nxt;
            r_valid   <= w_valid_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Next-state and next-datapath logic for the IDLE / SYNC / RUN sequencer
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latches).
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_gt_nxt      = r_gt;
        w_acc_nxt     = r_acc;
        w_acc_sat_nxt = r_acc_sat;
        w_result_nxt  = r_result;
        w_ovf_nxt     = r_ovf;
        w_valid_nxt   = 1'b0;
        w_finish      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_m_nxt       = mode;
                    w_acc_nxt     = ACC_ZERO;
                    w_acc_sat_nxt = 1'b0;
                    w_gt_nxt      = GT_LOAD;
                    w_state_nxt   = mode ? ST_SYNC : ST_RUN;
                end
            end

            ST_SYNC: begin
                if (w_edge) begin
                    w_acc_nxt   = ACC_ZERO;
                    w_state_nxt = ST_RUN;
                end else if (r_gt == 32'd0) begin
                    // No edge within the timeout window
                    w_result_nxt = ACC_ZERO;
                    w_ovf_nxt    = 1'b0;
                    w_finish     = 1'b1;
                end else begin
                    w_gt_nxt = r_gt - 32'd1;
                end
            end

            ST_RUN: begin
                if (!r_m) begin
                    w_acc_nxt     = w_gate_sum;
                    w_acc_sat_nxt = w_gate_ovf;
                    if (r_gt == 32'd0) begin
                        w_result_nxt = w_gate_sum;
                        w_ovf_nxt    = w_gate_ovf;
                        w_finish     = 1'b1;
                    end else begin
                        w_gt_nxt = r_gt - 32'd1;
                    end
                end else if (w_edge || w_acc_full) begin
                    // Terminating edge, or the count can grow no further
                    w_result_nxt = w_per_sum;
                    w_ovf_nxt    = w_acc_full;
                    w_finish     = 1'b1;
                end else begin
                    w_acc_nxt = r_acc + ACC_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Publish the result and either re-arm with no dead cycle or return to IDLE
        if (w_finish) begin
            w_valid_nxt = 1'b1;
            if (cont) begin
                w_gt_nxt      = GT_LOAD;
                w_acc_nxt     = ACC_ZERO;
                w_acc_sat_nxt = 1'b0;
                w_state_nxt   = r_m ? ST_SYNC : ST_RUN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign result = r_result;
    assign valid  = r_valid;
    assign ovf    = r_ovf;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: random sig_in waveforms are recorded as the CLK edge
// at which each rising edge becomes visible to the meter; expected results
// are then computed from that list of edge times with plain arithmetic.
`timescale 1ns/1ps

module tb_freq_meter;

    localparam int G  = 1000;
    localparam int G8 = 4000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        sig_in;
    logic        start;
    logic        start8;
    logic        mode;
    logic        cont;
    logic [31:0] result;
    logic        valid, ovf, busy;
    logic [7:0]  result8;
    logic        valid8, ovf8, busy8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // CLK edge numbers at which each sig_in rising edge is seen by the meter
    int strobes[$];

    bit sig_en   = 1'b0;
    bit rand_len = 1'b0;
    int hi_len   = 5;
    int lo_len   = 5;
    int ph_cnt   = 0;

    freq_meter #(.CW(32), .GATE_CYCLES(32'd1000)) dut (
        .CLK(CLK), .RESET(RESET), .sig_in(sig_in), .start(start), .mode(mode), .cont(cont),
        .result(result), .valid(valid), .ovf(ovf), .busy(busy)
    );

    freq_meter #(.CW(8), .GATE_CYCLES(32'd4000)) dut8 (
        .CLK(CLK), .RESET(RESET), .sig_in(sig_in), .start(start8), .mode(mode), .cont(cont),
        .result(result8), .valid(valid8), .ovf(ovf8), .busy(busy8)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // sig_in generator: phases of hi_len / lo_len cycles (or random), driven off the edge
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (!sig_en) begin
                sig_in = 1'b0;
                ph_cnt = 0;
            end else if (ph_cnt > 1) begin
                ph_cnt--;
            end else begin
                sig_in = ~sig_in;
                if (sig_in) begin
                    // two synchronizer flops, then the strobe is acted on at the third edge
                    strobes.push_back(cyc + 3);
                    ph_cnt = rand_len ? int'($urandom_range(1, 20)) : hi_len;
                end else begin
                    ph_cnt = rand_len ? int'($urandom_range(1, 20)) : lo_len;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------

    function automatic int first_strobe_after(input int t);
        for (int i = 0; i < strobes.size(); i++)
            if (strobes[i] > t) return strobes[i];
        return -1;
    endfunction

    // Gate: count strobes in edges s0+1 .. s0+g, result published at edge s0+g
    function automatic void model_gate(input int s0, input int g, input int cw,
                                       output int vc, output longint res, output bit o);
        longint n  = 0;
        longint mx = (longint'(1) << cw) - 1;
        for (int i = 0; i < strobes.size(); i++)
            if (strobes[i] >= s0 + 1 && strobes[i] <= s0 + g) n++;
        vc  = s0 + g;
        o   = (n > mx);
        res = o ? mx : n;
    endfunction

    // Period: first strobe a within the timeout, next strobe b; result b-a, capped
    function automatic void model_period(input int s0, input int g, input int cw,
                                         output int vc, output longint res, output bit o);
        longint mx = (longint'(1) << cw) - 1;
        int a = first_strobe_after(s0);
        int b;
        if (a < 0 || a > s0 + g) begin
            vc = s0 + g; res = 0; o = 1'b0;
        end else begin
            b = first_strobe_after(a);
            if (b < 0 || longint'(b - a) > mx) begin
                vc = int'(longint'(a) + mx + 1); res = mx; o = 1'b1;
            end else begin
                vc = b; res = b - a; o = 1'b0;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Called at a drive point; start is sampled at edge s0
    task automatic do_start(input bit which, input bit m, output int s0);
        mode = m;
        if (which) start8 = 1'b1;
        else start = 1'b1;
        s0 = cyc + 1;
        @(posedge CLK);
        #2;
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    // Waits for valid (bounded); vc=-1 when it never came. Returns at the next drive point.
    task automatic wait_valid(input bit which, input int budget,
                              output int vc, output longint res, output bit o);
        bit got = 1'b0;
        vc = -1; res = -1; o = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            if ((which ? valid8 : valid) === 1'b1) begin
                got = 1'b1;
                vc  = cyc;
                res = which ? longint'(result8) : longint'(result);
                o   = which ? ovf8 : ovf;
            end
        end
        @(posedge CLK);
        #2;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; start8 = 1'b0; mode = 1'b0; cont = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (result8 !== 8'd0) begin failures++; $display("FAIL reset_result8: got %0d want 0", result8); end
        checks++; if (valid8 !== 1'b0) begin failures++; $display("FAIL reset_valid8: got %b want 0", valid8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        tick(2);
    endtask

    task automatic test_gate_basic();
        int s0, vc, evc; longint res, eres; bit o, eo; bit seen = 1'b0;
        sig_en = 1'b1; rand_len = 1'b0; hi_len = 5; lo_len = 5;
        tick(30);
        do_start(0, 1'b0, s0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gate_busy_after_start: got %b want 1", busy); end
        wait_valid(0, G + 20, vc, res, o);
        model_gate(s0, G, 32, evc, eres, eo);
        checks++; if (vc !== evc) begin failures++; $display("FAIL gate_valid_cycle: got %0d want %0d", vc, evc); end
        checks++; if (res !== eres) begin failures++; $display("FAIL gate_result: got %0d want %0d", res, eres); end
        checks++; if (res !== 64'd100) begin failures++; $display("FAIL gate_result_10mhz: got %0d want 100", res); end
        checks++; if (o !== eo) begin failures++; $display("FAIL gate_ovf: got %b want %b", o, eo); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL gate_valid_width: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_idle_after: got %b want 0", busy); end
        for (int i = 0; i < G + 100; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL gate_single_valid: got extra valid=%b want 0", seen); end
        tick(1);
    endtask

    task automatic test_gate_random();
        int s0, vc, evc; longint res, eres; bit o, eo;
        rand_len = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(int'($urandom_range(1, 50)));
            do_start(0, 1'b0, s0);
            wait_valid(0, G + 20, vc, res, o);
            model_gate(s0, G, 32, evc, eres, eo);
            checks++; if (vc !== evc) begin failures++; $display("FAIL gate_rand%0d_cycle: got %0d want %0d", k, vc, evc); end
            checks++; if (res !== eres) begin failures++; $display("FAIL gate_rand%0d_result: got %0d want %0d", k, res, eres); end
            checks++; if (o !== eo) begin failures++; $display("FAIL gate_rand%0d_ovf: got %b want %b", k, o, eo); end
        end
    endtask

    task automatic test_period();
        int half[2] = '{50, 5};
        int want[2] = '{100, 10};
        int s0, s, vc, evc; longint res, eres; bit o, eo;
        rand_len = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hi_len = half[k]; lo_len = half[k];
            tick(120);
            do_start(0, 1'b1, s0);
            wait_valid(0, G + 20, vc, res, o);
            model_period(s0, G, 32, evc, eres, eo);
            checks++; if (vc !== evc) begin failures++; $display("FAIL period%0d_cycle: got %0d want %0d", k, vc, evc); end
            checks++; if (res !== eres) begin failures++; $display("FAIL period%0d_result: got %0d want %0d", k, res, eres); end
            checks++; if (res !== longint'(want[k])) begin failures++; $display("FAIL period%0d_nominal: got %0d want %0d", k, res, want[k]); end
            checks++; if (o !== eo) begin failures++; $display("FAIL period%0d_ovf: got %b want %b", k, o, eo); end
        end
        // Random waveform, continuous re-arm, then drop cont for the last result
        rand_len = 1'b1; cont = 1'b1;
        tick(10);
        do_start(0, 1'b1, s0);
        s = s0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, G + 50, vc, res, o);
            model_period(s, G, 32, evc, eres, eo);
            checks++; if (vc !== evc) begin failures++; $display("FAIL period_cont%0d_cycle: got %0d want %0d", k, vc, evc); end
            checks++; if (res !== eres) begin failures++; $display("FAIL period_cont%0d_result: got %0d want %0d", k, res, eres); end
            s = evc;
            if (k == 1) cont = 1'b0;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL period_cont_idle: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        int s0, vc, evc; longint res, eres; bit o, eo;
        rand_len = 1'b0; hi_len = 5; lo_len = 5;
        tick(20);
        do_start(1, 1'b0, s0);
        wait_valid(1, G8 + 20, vc, res, o);
        model_gate(s0, G8, 8, evc, eres, eo);
        checks++; if (vc !== evc) begin failures++; $display("FAIL sat_gate_cycle: got %0d want %0d", vc, evc); end
        checks++; if (res !== eres) begin failures++; $display("FAIL sat_gate_result: got %0d want %0d", res, eres); end
        checks++; if (res !== 64'd255 || o !== 1'b1) begin failures++; $display("FAIL sat_gate_nominal: got %0d/%b want 255/1", res, o); end
        checks++; if (o !== eo) begin failures++; $display("FAIL sat_gate_ovf: got %b want %b", o, eo); end
        hi_len = 500; lo_len = 500;
        tick(20);
        do_start(1, 1'b1, s0);
        wait_valid(1, 3000, vc, res, o);
        model_period(s0, G8, 8, evc, eres, eo);
        checks++; if (vc !== evc) begin failures++; $display("FAIL sat_period_cycle: got %0d want %0d", vc, evc); end
        checks++; if (res !== eres) begin failures++; $display("FAIL sat_period_result: got %0d want %0d", res, eres); end
        checks++; if (o !== eo) begin failures++; $display("FAIL sat_period_ovf: got %b want %b", o, eo); end
    endtask

    task automatic test_timeout();
        int s0, vc, evc; longint res, eres; bit o, eo;
        sig_en = 1'b0;
        tick(10);
        do_start(0, 1'b1, s0);
        wait_valid(0, G + 20, vc, res, o);
        model_period(s0, G, 32, evc, eres, eo);
        checks++; if (vc !== evc) begin failures++; $display("FAIL timeout_cycle: got %0d want %0d", vc, evc); end
        checks++; if (res !== eres) begin failures++; $display("FAIL timeout_result: got %0d want %0d", res, eres); end
        checks++; if (o !== eo) begin failures++; $display("FAIL timeout_ovf: got %b want %b", o, eo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: got %b want 0", busy); end
    endtask

    task automatic test_continuous();
        int s, vc, evc; longint res, eres; bit o, eo; bit seen = 1'b0;
        sig_en = 1'b1; rand_len = 1'b0; hi_len = 5; lo_len = 5;
        tick(20);
        cont = 1'b1;
        do_start(0, 1'b0, s);
        for (int k = 0; k < 4; k++) begin
            wait_valid(0, G + 10, vc, res, o);
            model_gate(s, G, 32, evc, eres, eo);
            checks++; if (vc !== evc) begin failures++; $display("FAIL cont%0d_cycle: got %0d want %0d", k, vc, evc); end
            checks++; if (res !== eres) begin failures++; $display("FAIL cont%0d_result: got %0d want %0d", k, res, eres); end
            checks++; if (o !== eo) begin failures++; $display("FAIL cont%0d_ovf: got %b want %b", k, o, eo); end
            s = evc;
            if (k == 0) begin
                // start and mode wiggled while busy must be ignored
                start = 1'b1; mode = 1'b1;
                tick(3);
                start = 1'b0;
            end
            if (k == 2) begin
                cont = 1'b0; mode = 1'b0;
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_stop_idle: got %b want 0", busy); end
        for (int i = 0; i < G + 100; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL cont_stop_no_more: got extra valid=%b want 0", seen); end
        tick(1);
    endtask

    task automatic test_reset_mid();
        int s0, vc, evc; longint res, eres; bit o, eo; bit bad = 1'b0;
        do_start(0, 1'b0, s0);
        tick(500);
        RESET = 1'b1;
        #1;
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rst_mid_result: got %0d want 0", result); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (result !== 32'd0 || valid !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rst_mid_held: got nonzero output=%b want 0", bad); end
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < G + 100; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid: got valid=%b want 0", bad); end
        tick(5);
        do_start(0, 1'b0, s0);
        wait_valid(0, G + 20, vc, res, o);
        model_gate(s0, G, 32, evc, eres, eo);
        checks++; if (vc !== evc) begin failures++; $display("FAIL rst_after_cycle: got %0d want %0d", vc, evc); end
        checks++; if (res !== eres) begin failures++; $display("FAIL rst_after_result: got %0d want %0d", res, eres); end
        checks++; if (res !== 64'd100) begin failures++; $display("FAIL rst_after_nominal: got %0d want 100", res); end
        checks++; if (o !== eo) begin failures++; $display("FAIL rst_after_ovf: got %b want %b", o, eo); end
    endtask

    initial begin
        test_reset();
        test_gate_basic();
        test_gate_random();
        test_period();
        test_saturation();
        test_timeout();
        test_continuous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
